// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM states, HD44780 opcodes and init sequence for lcd_ctrl.
// LCD_INIT_EN adds the PWRUP/INIT states used by the power-on init sequence.
package lcd_pkg;
  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, WAIT
`ifdef LCD_INIT_EN
    , PWRUP, INIT
`endif
  } state_t;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME = 8'h02;
  localparam logic [7:0] INIT_FUNC_SET = 8'h38;
  localparam logic [7:0] INIT_DISP_ON = 8'h0C;
  localparam logic [7:0] INIT_ENTRY = 8'h06;
  localparam int INIT_LEN = 4;
  function automatic logic [7:0] init_byte(input logic [1:0] i);
    return i == 2'd0 ? INIT_FUNC_SET : i == 2'd1 ? INIT_DISP_ON : i == 2'd2 ? INIT_ENTRY : CMD_CLEAR;
  endfunction
  // Clear and home need the long execution wait.
  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d == CMD_CLEAR || d == CMD_HOME);
  endfunction
endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter; done is high while the count equals 1.
// Ports: clk, rst_n (async active-low), load, load_value [W], done.
module lcd_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= load_value;
    else if (count != '0) count <= count - 1'b1;
  assign done = count == W'(1);
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style write-only LCD strobe sequencer with per-command exec waits.
// Ports: i_clk, i_rst (async active-low); i_cmd_valid/o_cmd_ready/i_cmd_rs/i_cmd_data command
// handshake; o_busy = !o_cmd_ready; o_lcd_on/en/rs/rw/data panel pins.
// Define LCD_INIT_EN to add the power-up delay and the 0x38/0x0C/0x06/0x01 init sequence.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 12,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned EXEC_CYC = 2000,
  parameter int unsigned CLEAR_CYC = 82000,
  parameter int unsigned POWERUP_CYC = 2000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_rs,
  input  logic [7:0] i_cmd_data,
  output logic       o_busy,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);
  localparam int unsigned MAX_CYC = CLEAR_CYC > POWERUP_CYC ? CLEAR_CYC : POWERUP_CYC;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] SETUP_L = CW'(SETUP_CYC);
  localparam logic [CW-1:0] PULSE_L = CW'(PULSE_CYC);
  localparam logic [CW-1:0] HOLD_L = CW'(HOLD_CYC);
  localparam logic [CW-1:0] EXEC_L = CW'(EXEC_CYC);
  localparam logic [CW-1:0] CLEAR_L = CW'(CLEAR_CYC);
`ifdef LCD_INIT_EN
  localparam logic [CW-1:0] PWRUP_L = CW'(POWERUP_CYC);
  localparam state_t RST_STATE = PWRUP;
  logic [2:0] idx;
`else
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state, state_nx;
  logic on, accept, load, done, lcd_rs;
  logic [7:0] lcd_data;
  logic [CW-1:0] load_value;
  lcd_timer #(.W(CW)) u_timer (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .load      (load),
    .load_value(load_value),
    .done      (done)
  );
  // on is the "out of reset for at least one edge" flag; it gates ready so reset forces ready low.
  assign o_cmd_ready = on && state == IDLE;
  assign accept = o_cmd_ready && i_cmd_valid;
  assign o_busy = !o_cmd_ready;
  assign o_lcd_on = on;
  assign o_lcd_en = state == PULSE;
  assign o_lcd_rs = lcd_rs;
  assign o_lcd_rw = 1'b0;
  assign o_lcd_data = lcd_data;
  always_comb begin
    state_nx = state;
    load = 1'b0;
    load_value = SETUP_L;
    case (state)
      IDLE: if (accept) begin
        state_nx = SETUP;
        load = 1'b1;
      end
      SETUP: if (done) begin
        state_nx = PULSE;
        load = 1'b1;
        load_value = PULSE_L;
      end
      PULSE: if (done) begin
        state_nx = HOLD;
        load = 1'b1;
        load_value = HOLD_L;
      end
      HOLD: if (done) begin
        state_nx = WAIT;
        load = 1'b1;
        load_value = is_long(lcd_rs, lcd_data) ? CLEAR_L : EXEC_L;
      end
`ifdef LCD_INIT_EN
      WAIT: if (done) state_nx = idx == 3'(INIT_LEN) ? IDLE : INIT;
      // The first edge after reset release loads the power-up delay.
      PWRUP: begin
        load = !on;
        load_value = PWRUP_L;
        if (on && done) state_nx = INIT;
      end
      INIT: begin
        state_nx = SETUP;
        load = 1'b1;
      end
`else
      WAIT: if (done) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state <= RST_STATE;
      on <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_data <= '0;
    end else begin
      state <= state_nx;
      on <= 1'b1;
      if (accept) begin
        lcd_rs <= i_cmd_rs;
        lcd_data <= i_cmd_data;
      end
`ifdef LCD_INIT_EN
      if (state == INIT) begin
        lcd_rs <= 1'b0;
        lcd_data <= init_byte(idx[1:0]);
      end
`endif
    end
`ifdef LCD_INIT_EN
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) idx <= '0;
    else if (state == INIT) idx <= idx + 1'b1;
`endif
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: self-checking bench for lcd_ctrl (table vectors, hand sequences, random traffic vs model).
// CLEAR_CYC is shortened here to keep the run short; all expectations derive from the local params.
module tb_lcd_ctrl;
  localparam int S = 2, P = 12, H = 2, EXE = 2000, CLR = 6000, PWR = 100;
  localparam int EXE_T = S + P + H + EXE;
  localparam int CLR_T = S + P + H + CLR;
  localparam int BUDGET = 10000;
  logic clk = 0, rst_n = 1, cmd_valid = 0, cmd_rs = 0;
  logic [7:0] cmd_data = 0;
  logic o_cmd_ready, o_busy, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;
  int n_cmp = 0, n_fail = 0;
  logic mon_en = 0;
  lcd_ctrl #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .EXEC_CYC(EXE), .CLEAR_CYC(CLR), .POWERUP_CYC(PWR)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_rs(cmd_rs), .i_cmd_data(cmd_data), .o_busy(o_busy), .o_lcd_on(o_lcd_on),
    .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Transaction-level model: a command accepted at edge k keeps the block busy until edge k+T,
  // with EN high for edges k+S .. k+S+P-1.
  longint cyc = 0, start = -100000, done_at = 0;
  logic m_on = 0, m_rs = 0;
  logic [7:0] m_data = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_on = 0; m_rs = 0; m_data = 0; start = -100000; done_at = 0;
    end else begin
      cyc++;
      if (m_on && cyc - 1 >= done_at && cmd_valid) begin
        start = cyc;
        m_rs = cmd_rs;
        m_data = cmd_data;
        done_at = cyc + ((!cmd_rs && (cmd_data == 8'h01 || cmd_data == 8'h02)) ? CLR_T : EXE_T);
      end
      m_on = 1;
    end
  always @(negedge clk)
    if (mon_en) begin
      logic er, ee;
      er = m_on && cyc >= done_at;
      ee = m_on && cyc >= start + S && cyc < start + S + P;
      check("monitor {ready,busy,on,en,rs,rw,data}",
            {o_cmd_ready, o_busy, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data},
            {er, !er, m_on, ee, m_rs, 1'b0, m_data});
    end
  task automatic wait_ready();
    for (int g = 0; g < BUDGET && !o_cmd_ready; g++) @(negedge clk);
  endtask
  task automatic run_cmd(input logic rs, input logic [7:0] d, output int busy_n, output int en_n,
                         output int en_first, output int bad);
    busy_n = 0; en_n = 0; en_first = -1; bad = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_rs = rs; cmd_data = d;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 0; cmd_rs = ~rs; cmd_data = ~d;
    @(negedge clk);
    for (int g = 0; g < BUDGET && !o_cmd_ready; g++) begin
      if (o_lcd_en) begin
        if (en_first < 0) en_first = busy_n;
        en_n++;
      end
      if (o_lcd_rs !== rs || o_lcd_data !== d) bad++;
      busy_n++;
      @(negedge clk);
    end
  endtask
  typedef struct {logic rs; logic [7:0] d; int busy; int en_len; int en_first;} vec_t;
  vec_t tbl[6];
  initial begin
    tbl[0] = '{1'b1, 8'h41, EXE_T, P, S};
    tbl[1] = '{1'b0, 8'h01, CLR_T, P, S};
    tbl[2] = '{1'b0, 8'h0C, EXE_T, P, S};
    tbl[3] = '{1'b0, 8'h02, CLR_T, P, S};
    tbl[4] = '{1'b1, 8'h01, EXE_T, P, S};
    tbl[5] = '{1'b0, 8'h03, EXE_T, P, S};
    #1 rst_n = 0;
`ifndef LCD_INIT_EN
    mon_en = 1;
`endif
    repeat (3) @(negedge clk);
    check("reset ready", o_cmd_ready, 0);
    check("reset busy", o_busy, 1);
    check("reset on", o_lcd_on, 0);
    check("reset en", o_lcd_en, 0);
    check("reset data", {o_lcd_rs, o_lcd_data}, 0);
    rst_n = 1;
    @(negedge clk);
`ifdef LCD_INIT_EN
    begin
      logic [7:0] exp_seq[4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
      logic [7:0] got[$];
      logic prev_en = 0;
      int early = 0;
      for (int g = 0; g < 4 * BUDGET && !o_cmd_ready; g++) begin
        if (o_lcd_en && !prev_en) begin
          got.push_back(o_lcd_data);
          if (o_lcd_rs !== 1'b0) early++;
        end
        prev_en = o_lcd_en;
        @(negedge clk);
      end
      check("init pulse count", got.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("init byte %0d", i), i < got.size() ? got[i] : 8'hxx, exp_seq[i]);
      check("init rs low", early, 0);
      check("init ready after", o_cmd_ready, 1);
    end
`else
    check("release ready", o_cmd_ready, 1);
    check("release on", o_lcd_on, 1);
    check("release en", o_lcd_en, 0);
    check("release rw", o_lcd_rw, 0);
    foreach (tbl[i]) begin
      int bn, en, ef, bad;
      run_cmd(tbl[i].rs, tbl[i].d, bn, en, ef, bad);
      check($sformatf("row%0d busy cycles", i), bn, tbl[i].busy);
      check($sformatf("row%0d en cycles", i), en, tbl[i].en_len);
      check($sformatf("row%0d en start", i), ef, tbl[i].en_first);
      check($sformatf("row%0d rs/data unstable", i), bad, 0);
    end
    // Request pending while busy is taken on the first IDLE cycle; later input changes are ignored.
    @(negedge clk);
    cmd_valid = 1; cmd_rs = 1; cmd_data = 8'h41;
    wait_ready();
    @(posedge clk); #1;
    cmd_data = 8'h55;
    @(negedge clk);
    check("pending not taken while busy", o_lcd_data, 8'h41);
    wait_ready();
    check("idle reached with pending", o_cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_rs = 0; cmd_data = 8'hAA;
    @(negedge clk);
    check("pending accepted first idle", o_cmd_ready, 0);
    check("pending data latched", o_lcd_data, 8'h55);
    repeat (5) @(negedge clk);
    check("mid-pulse en", o_lcd_en, 1);
    check("mid-pulse data unchanged", {o_lcd_rs, o_lcd_data}, {1'b1, 8'h55});
    wait_ready();
    // Reset during PULSE drops EN at once and the command is not resumed.
    @(negedge clk);
    cmd_valid = 1; cmd_rs = 1; cmd_data = 8'h33;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 0;
    for (int g = 0; g < 50 && !o_lcd_en; g++) @(negedge clk);
    check("pulse reached", o_lcd_en, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("abort en low", o_lcd_en, 0);
    check("abort ready low", o_cmd_ready, 0);
    check("abort data", {o_lcd_rs, o_lcd_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    begin
      int en_seen = 0;
      for (int g = 0; g < EXE_T + 50; g++) begin
        @(negedge clk);
        if (o_lcd_en) en_seen++;
      end
      check("no pulse after abort", en_seen, 0);
      check("ready after abort", o_cmd_ready, 1);
    end
    // Random traffic, requests held until accepted; the monitor checks every cycle.
    begin
      logic was_ready = 0;
      for (int c = 0; c < 20000; c++) begin
        @(negedge clk);
        if (cmd_valid && was_ready) cmd_valid = 0;
        else if (!cmd_valid && $urandom_range(0, 3) == 0) begin
          cmd_valid = 1;
          cmd_rs = 1'($urandom);
          cmd_data = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
        end
        was_ready = o_cmd_ready;
      end
      cmd_valid = 0;
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
